// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store memory initiator.
// Size encodings, FSM states and the alignment rule.
package lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_e;

  function automatic logic is_misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    return (size == SIZE_H && off[0])
        || (size == SIZE_W && off != 2'd0)
        || (size == 2'd3);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store replication/mask and load
// shift with sign or zero extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_mask,
  output logic [31:0] ld_data
);

  logic [31:0] sh;

  always_comb begin
    sh      = rdata >> {off, 3'b000};
    wr_data = wdata;
    wr_mask = 4'h0;
    ld_data = sh;
    unique case (1'b1)
      (size == SIZE_B): begin
        wr_data = {4{wdata[7:0]}};
        wr_mask = 4'b0001 << off;
        ld_data = {{24{sh[7] & ~is_unsigned}}, sh[7:0]};
      end
      (size == SIZE_H): begin
        wr_data = {2{wdata[15:0]}};
        wr_mask = 4'b0011 << off;
        ld_data = {{16{sh[15] & ~is_unsigned}}, sh[15:0]};
      end
      (size == SIZE_W): begin
        wr_data = wdata;
        wr_mask = 4'hF;
        ld_data = sh;
      end
      default: begin
        wr_data = wdata;
        wr_mask = 4'h0;
        ld_data = sh;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Single-outstanding load/store initiator driving the
// memory port; all outputs registered.
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int MEM_LATENCY = 0,
  parameter int XLEN        = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_misaligned,
  output logic            mem_valid,
  output logic            mem_write_enable,
  output logic [XLEN-1:0] mem_write_addr,
  output logic [XLEN-1:0] mem_write_data,
  output logic [3:0]      mem_write_mask,
  output logic [XLEN-1:0] mem_read_addr,
  input  logic [XLEN-1:0] mem_read_data
);

  state_e      state;
  logic [3:0]  cnt;
  logic        wr_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;

  logic        idle;
  logic [31:0] al_wdata;
  logic [3:0]  al_mask;
  logic [31:0] al_rdata;

  assign idle = (state == S_IDLE);

  // Store lanes come from the live request, load lanes from the latch.
  lsu_lane_align u_align (
    .size        (idle ? req_size : size_q),
    .off         (idle ? req_addr[1:0] : off_q),
    .is_unsigned (uns_q),
    .wdata       (req_wdata),
    .rdata       (mem_read_data),
    .wr_data     (al_wdata),
    .wr_mask     (al_mask),
    .ld_data     (al_rdata)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= S_IDLE;
      cnt              <= '0;
      wr_q             <= 1'b0;
      uns_q            <= 1'b0;
      size_q           <= '0;
      off_q            <= '0;
      req_ready        <= 1'b0;
      rsp_valid        <= 1'b0;
      rsp_rdata        <= '0;
      rsp_misaligned   <= 1'b0;
      mem_valid        <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_write_addr   <= '0;
      mem_write_data   <= '0;
      mem_write_mask   <= '0;
      mem_read_addr    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready      <= 1'b0;
            wr_q           <= req_write;
            uns_q          <= req_unsigned;
            size_q         <= req_size;
            off_q          <= req_addr[1:0];
            mem_write_addr <= {req_addr[31:2], 2'b00};
            mem_read_addr  <= {req_addr[31:2], 2'b00};
            mem_write_data <= al_wdata;
            mem_write_mask <= al_mask;
            if (is_misaligned(req_size, req_addr[1:0])) begin
              state          <= S_RESP;
              rsp_valid      <= 1'b1;
              rsp_misaligned <= 1'b1;
              rsp_rdata      <= '0;
            end else begin
              state            <= S_ACCESS;
              cnt              <= 4'(MEM_LATENCY);
              mem_valid        <= 1'b1;
              mem_write_enable <= req_write;
            end
          end
        end
        S_ACCESS: begin
          mem_write_enable <= 1'b0;
          if (cnt == 4'd0) begin
            state          <= S_RESP;
            mem_valid      <= 1'b0;
            rsp_valid      <= 1'b1;
            rsp_misaligned <= 1'b0;
            rsp_rdata      <= wr_q ? '0 : al_rdata;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
